cva6_ptw_dcache_responder: RTL and testbench
============================================

Name: cva6_ptw_dcache_responder

Overview:
- Responder end of the PTW data-cache load port. Accepts the split index/tag read requests the page-table walker issues and serves them from a simple request/grant/rvalid backing-memory port.
- Returns read data and ID with the CVA6 `data_rvalid` / `data_rid` / `data_ruser` handshake.
- Honours `kill_req` and `flush_i`.
- Used as the PTW-side cache model in unit benches and as a dedicated PTW port on the FPGA memory path.

Parameters:
- INDEX_W, 12, width of address_index
- TAG_W, 44, width of address_tag
- DATA_W, 64, read data width
- ID_W, 3, transaction ID width
- BE_W, 8, byte-enable width (DATA_W/8)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  abandon any in-flight request
- data_req_i  in  1  index-phase request
- data_we_i  in  1  write request (unsupported)
- address_index_i  in  INDEX_W  index-phase address
- data_be_i  in  BE_W  byte enables
- data_size_i  in  2  log2 access size
- data_id_i  in  ID_W  request ID
- tag_valid_i  in  1  tag phase valid
- address_tag_i  in  TAG_W  tag-phase address
- kill_req_i  in  1  kill outstanding request
- data_gnt_o  out  1  index phase accepted
- data_rvalid_o  out  1  response valid (one-cycle pulse)
- data_rdata_o  out  DATA_W  response data
- data_rid_o  out  ID_W  response ID
- data_ruser_o  out  1  response error (bus error)
- mem_req_o  out  1  backing read request
- mem_addr_o  out  TAG_W+INDEX_W  {tag,index}
- mem_gnt_i  in  1  backing request accepted
- mem_rvalid_i  in  1  backing data valid
- mem_rdata_i  in  DATA_W  backing data
- mem_err_i  in  1  backing error, qualified by mem_rvalid_i
- busy_o  out  1  state != IDLE
- proto_err_o  out  1  one-cycle pulse on rejected write request

Behaviour:
- Reset (rst_i=1 at a clock edge) forces IDLE; every output is 0, including data_rdata_o and data_rid_o. Reset mid-transaction discards it; no rvalid is produced and any later mem_rvalid_i is ignored.
- FSM states: IDLE, TAG, MREQ, MWAIT, DRAIN.
- IDLE:
  - data_gnt_o = data_req_i & ~data_we_i & ~flush_i, combinational.
  - On grant, latch id/be/size/index and go to TAG.
  - data_req_i & data_we_i pulses proto_err_o and is never granted.
- TAG:
  - tag_valid_i: latch tag, go to MREQ.
  - kill_req_i or flush_i without tag_valid_i: go to IDLE with no response. Kill has priority when it coincides with tag_valid_i.
  - Otherwise wait; the tag normally arrives the cycle after grant.
- MREQ:
  - mem_req_o=1 with a stable mem_addr_o until mem_gnt_i, then go to MWAIT.
  - kill_req_i or flush_i: go to DRAIN if mem_gnt_i is high that cycle, else IDLE. The request is withdrawn only before grant.
- MWAIT:
  - On mem_rvalid_i, register data_rdata_o=mem_rdata_i, data_ruser_o=mem_err_i, data_rid_o=latched id, and pulse data_rvalid_o for one cycle on the next edge; go to IDLE.
  - kill_req_i or flush_i before mem_rvalid_i: go to DRAIN.
  - If kill and mem_rvalid_i coincide, the response is suppressed.
- DRAIN: wait for mem_rvalid_i, discard it, go to IDLE. data_gnt_o=0.
- Only one outstanding request. data_gnt_o is 0 in every state except IDLE.
- Minimum latency: gnt at cycle N, tag at N+1, mem_req_o at N+2 (granted same cycle), mem_rvalid_i at N+3, data_rvalid_o at N+4.
- data_rdata_o holds its value after the rvalid pulse until the next response.
- data_be_i and data_size_i are latched and available for the optional check only.

Optional Feature:
CVA6_PTW_RSP_ALIGN_CHECK_EN
- Defined: in TAG, when tag_valid_i arrives and the latched index is misaligned for the latched size (size 3: index[2:0]!=0; size 2: index[1:0]!=0; size 1: index[0]!=0), skip MREQ and MWAIT. Pulse data_rvalid_o the next cycle with data_ruser_o=1, data_rdata_o=0, and the latched ID.
- Undefined: no check; all requests go to memory.

Test Plan:
- Aligned read, index 0x018, tag 0x0000_0000_123, id 5, mem grants immediately and returns 0xDEAD_BEEF_0000_1111 one cycle later -> mem_addr_o=0x123018; data_rvalid_o at N+4 with rdata 0xDEAD_BEEF_0000_1111, rid 5, ruser 0.
- mem_gnt_i delayed 3 cycles, then mem_rvalid_i with mem_err_i=1, id 2 -> mem_req_o held 4 cycles with stable address; response has rid 2, ruser 1.
- kill_req_i in TAG -> no mem_req_o, no rvalid; busy_o falls next cycle. A new request the following cycle is granted.
- flush_i in MWAIT, mem_rvalid_i 2 cycles later -> no data_rvalid_o; data_gnt_o stays 0 until DRAIN completes; then a new request completes normally.
- data_req_i with data_we_i=1 -> data_gnt_o=0, one-cycle proto_err_o, state stays IDLE.
- Macro defined, size 3, index 0x01C -> no mem_req_o; rvalid 2 cycles after grant with ruser 1. Macro undefined -> normal memory read.

Source files
------------

// File: rtl/cva6_ptw_dcache_responder_if.sv
// PTW data-cache load port: split index/tag request phases and the rvalid/rid/ruser response.
// Signal suffixes are relative to the responder: the slave modport is the responder side.
interface cva6_ptw_dcache_responder_if #(
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 44,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 3,
  parameter int BE_W    = 8
);
  logic               data_req_i;
  logic               data_we_i;
  logic [INDEX_W-1:0] address_index_i;
  logic [BE_W-1:0]    data_be_i;
  logic [1:0]         data_size_i;
  logic [ID_W-1:0]    data_id_i;
  logic               tag_valid_i;
  logic [TAG_W-1:0]   address_tag_i;
  logic               kill_req_i;
  logic               data_gnt_o;
  logic               data_rvalid_o;
  logic [DATA_W-1:0]  data_rdata_o;
  logic [ID_W-1:0]    data_rid_o;
  logic               data_ruser_o;

  modport slave (
    input  data_req_i, data_we_i, address_index_i, data_be_i, data_size_i, data_id_i,
           tag_valid_i, address_tag_i, kill_req_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_rid_o, data_ruser_o
  );

  modport master (
    output data_req_i, data_we_i, address_index_i, data_be_i, data_size_i, data_id_i,
           tag_valid_i, address_tag_i, kill_req_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_rid_o, data_ruser_o
  );
endinterface

// File: rtl/cva6_ptw_dcache_responder.sv
// Serves PTW index/tag read requests from a req/gnt/rvalid backing memory, one outstanding at a time.
// Optional macro CVA6_PTW_RSP_ALIGN_CHECK_EN: answer misaligned requests with an error, bypassing memory.
module cva6_ptw_dcache_responder #(
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 44,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 3,
  parameter int BE_W    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  cva6_ptw_dcache_responder_if.slave port,
  output logic                     mem_req_o,
  output logic [TAG_W+INDEX_W-1:0] mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_err_i,
  output logic                     busy_o,
  output logic                     proto_err_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] TAG   = 3'd1;
  localparam logic [2:0] MREQ  = 3'd2;
  localparam logic [2:0] MWAIT = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [ID_W-1:0]    id_q;
  logic [BE_W-1:0]    be_q;
  logic [1:0]         size_q;
  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   tag_q;
  logic               rvalid_q, ruser_q, proto_err_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [ID_W-1:0]    rid_q;

  logic              idle, abort, accept;
  logic              rsp_fire, rsp_err;
  logic [DATA_W-1:0] rsp_data;

`ifdef CVA6_PTW_RSP_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [INDEX_W-1:0] idx, input logic [1:0] size);
    case (size)
      2'd3:    return idx[2:0] != 3'd0;
      2'd2:    return idx[1:0] != 2'd0;
      2'd1:    return idx[0];
      default: return 1'b0;
    endcase
  endfunction
`endif

  assign idle   = (state_q == IDLE);
  assign abort  = port.kill_req_i | flush_i;
  assign accept = idle & port.data_req_i & ~port.data_we_i & ~flush_i & ~rst_i;

  always_comb begin
    state_d  = state_q;
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    case (state_q)
      IDLE: if (accept) state_d = TAG;
      TAG: begin
        if (abort) begin
          state_d = IDLE;
        end else if (port.tag_valid_i) begin
`ifdef CVA6_PTW_RSP_ALIGN_CHECK_EN
          if (misaligned(index_q, size_q)) begin
            state_d  = IDLE;
            rsp_fire = 1'b1;
            rsp_err  = 1'b1;
          end else begin
            state_d = MREQ;
          end
`else
          state_d = MREQ;
`endif
        end
      end
      // Once the memory has granted, its response must still be absorbed.
      MREQ: begin
        if (abort)          state_d = mem_gnt_i ? DRAIN : IDLE;
        else if (mem_gnt_i) state_d = MWAIT;
      end
      MWAIT: begin
        if (mem_rvalid_i) begin
          state_d  = IDLE;
          rsp_fire = ~abort;
          rsp_err  = mem_err_i;
          rsp_data = mem_rdata_i;
        end else if (abort) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   if (mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rid_q       <= '0;
      ruser_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rvalid_q    <= rsp_fire;
      proto_err_q <= idle & port.data_req_i & port.data_we_i;
      if (rsp_fire) begin
        rdata_q <= rsp_data;
        rid_q   <= id_q;
        ruser_q <= rsp_err;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      id_q    <= port.data_id_i;
      be_q    <= port.data_be_i;
      size_q  <= port.data_size_i;
      index_q <= port.address_index_i;
    end
    if (state_q == TAG && port.tag_valid_i) tag_q <= port.address_tag_i;
  end

  // Byte enables (and size when the check is compiled out) are captured but not consumed.
  logic unused_attr;
  assign unused_attr = ^{be_q, size_q};

  assign port.data_gnt_o    = accept;
  assign port.data_rvalid_o = rvalid_q;
  assign port.data_rdata_o  = rdata_q;
  assign port.data_rid_o    = rid_q;
  assign port.data_ruser_o  = ruser_q;
  assign mem_req_o          = (state_q == MREQ);
  assign mem_addr_o         = (state_q == MREQ) ? {tag_q, index_q} : '0;
  assign busy_o             = ~idle;
  assign proto_err_o        = proto_err_q;

endmodule

// File: tb/tb_cva6_ptw_dcache_responder.sv
// Directed bench for cva6_ptw_dcache_responder: table of read transactions plus abort/reset sequences.
module tb_cva6_ptw_dcache_responder;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        mem_req, mem_gnt, mem_rvalid, mem_err, busy, proto_err;
  logic [55:0] mem_addr;
  logic [63:0] mem_rdata;

  int total = 0;
  int passed = 0;

  cva6_ptw_dcache_responder_if #(.INDEX_W(12), .TAG_W(44), .DATA_W(64), .ID_W(3), .BE_W(8)) bus ();

  cva6_ptw_dcache_responder #(.INDEX_W(12), .TAG_W(44), .DATA_W(64), .ID_W(3), .BE_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .port(bus),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .busy_o(busy), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] idx;
    logic [43:0] tag;
    logic [2:0]  id;
    logic [1:0]  size;
    int          gd;
    int          rd;
    logic [63:0] mdata;
    logic        merr;
    logic [55:0] exp_addr;
    int          exp_req;
    int          exp_lat;
    logic [63:0] exp_data;
    logic        exp_user;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic run_txn(input vec_t v, input int n);
    int rv_cnt = 0, rv_cyc = -1, req_cnt = 0, gnt_cyc = -1;
    logic addr_ok = 1'b1;
    logic [63:0] got_d = '0;
    logic [2:0]  got_id = '0;
    logic        got_u = 1'b0;
    @(negedge clk);
    bus.data_req_i = 1'b1; bus.address_index_i = v.idx; bus.data_id_i = v.id;
    bus.data_size_i = v.size; bus.data_be_i = 8'hFF; bus.data_we_i = 1'b0;
    #1 chk($sformatf("v%0d gnt", n), bus.data_gnt_o, 1);
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.tag_valid_i = 1'b1; bus.address_tag_i = v.tag;
    chk($sformatf("v%0d busy", n), busy, 1);
    for (int c = 2; c < v.exp_lat + 3; c++) begin
      @(negedge clk);
      bus.tag_valid_i = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (bus.data_rvalid_o) begin
        rv_cnt++; rv_cyc = c;
        got_d = bus.data_rdata_o; got_id = bus.data_rid_o; got_u = bus.data_ruser_o;
      end
      if (mem_req) begin
        if (mem_addr !== v.exp_addr) addr_ok = 1'b0;
        if (req_cnt == v.gd) begin mem_gnt = 1'b1; gnt_cyc = c; end
        req_cnt++;
      end
      if (gnt_cyc >= 0 && c == gnt_cyc + 1 + v.rd) begin
        mem_rvalid = 1'b1; mem_rdata = v.mdata; mem_err = v.merr;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk($sformatf("v%0d rvalid_count", n), rv_cnt, 1);
    chk($sformatf("v%0d rvalid_cycle", n), rv_cyc, v.exp_lat);
    chk($sformatf("v%0d rdata", n), got_d, v.exp_data);
    chk($sformatf("v%0d rid", n), got_id, v.id);
    chk($sformatf("v%0d ruser", n), got_u, v.exp_user);
    chk($sformatf("v%0d mem_req_cycles", n), req_cnt, v.exp_req);
    chk($sformatf("v%0d mem_addr_stable", n), addr_ok, 1);
    chk($sformatf("v%0d busy_end", n), busy, 0);
    chk($sformatf("v%0d rdata_hold", n), bus.data_rdata_o, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'h018, 44'h123, 3'd5, 2'd3, 0, 0, 64'hDEAD_BEEF_0000_1111, 1'b0,
                56'h123018, 1, 4, 64'hDEAD_BEEF_0000_1111, 1'b0};
    vecs[1] = '{12'h000, 44'h0AB_CDEF_0123, 3'd2, 2'd3, 3, 0, 64'h0123_4567_89AB_CDEF, 1'b1,
                56'h0A_BCDE_F012_3000, 4, 7, 64'h0123_4567_89AB_CDEF, 1'b1};
    vecs[2] = '{12'hFFF, 44'hFFF_FFFF_FFFF, 3'd7, 2'd0, 1, 2, 64'hFFFF_0000_FFFF_0000, 1'b0,
                56'hFF_FFFF_FFFF_FFFF, 2, 7, 64'hFFFF_0000_FFFF_0000, 1'b0};
`ifdef CVA6_PTW_RSP_ALIGN_CHECK_EN
    vecs[3] = '{12'h01C, 44'h55, 3'd1, 2'd3, 0, 0, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0,
                56'h5501C, 0, 2, 64'h0, 1'b1};
`else
    vecs[3] = '{12'h01C, 44'h55, 3'd1, 2'd3, 0, 0, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0,
                56'h5501C, 1, 4, 64'h5A5A_5A5A_A5A5_A5A5, 1'b0};
`endif

    rst = 1'b1; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b0; bus.address_index_i = '0; bus.data_be_i = '0;
    bus.data_size_i = 2'd3; bus.data_id_i = '0; bus.tag_valid_i = 1'b0; bus.address_tag_i = '0;
    bus.kill_req_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst gnt", bus.data_gnt_o, 0);
    chk("rst rvalid", bus.data_rvalid_o, 0);
    chk("rst rdata", bus.data_rdata_o, 0);
    chk("rst rid", bus.data_rid_o, 0);
    chk("rst ruser", bus.data_ruser_o, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst proto_err", proto_err, 0);
    bus.data_req_i = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_txn(vecs[i], i);

    // Write request: never granted, one-cycle protocol error.
    @(negedge clk);
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1;
    #1 chk("we gnt", bus.data_gnt_o, 0);
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0;
    chk("we proto_err", proto_err, 1);
    chk("we busy", busy, 0);
    @(negedge clk);
    chk("we proto_err_pulse", proto_err, 0);

    // Kill in TAG coinciding with tag_valid: no memory request, back to IDLE.
    @(negedge clk);
    bus.data_req_i = 1'b1; bus.address_index_i = 12'h010; bus.data_id_i = 3'd3;
    #1 chk("kill gnt", bus.data_gnt_o, 1);
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.tag_valid_i = 1'b1; bus.address_tag_i = 44'h42; bus.kill_req_i = 1'b1;
    chk("kill busy_tag", busy, 1);
    @(negedge clk);
    bus.tag_valid_i = 1'b0; bus.kill_req_i = 1'b0;
    chk("kill busy_fall", busy, 0);
    chk("kill mem_req", mem_req, 0);
    chk("kill rvalid", bus.data_rvalid_o, 0);
    bus.data_req_i = 1'b1;
    #1 chk("kill regnt", bus.data_gnt_o, 1);
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.kill_req_i = 1'b1;
    @(negedge clk);
    bus.kill_req_i = 1'b0;
    chk("kill2 busy", busy, 0);
    chk("kill2 rvalid", bus.data_rvalid_o, 0);

    // Kill in MREQ before grant withdraws the request.
    @(negedge clk);
    bus.data_req_i = 1'b1; bus.address_index_i = 12'h018;
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.tag_valid_i = 1'b1; bus.address_tag_i = 44'h31;
    @(negedge clk);
    bus.tag_valid_i = 1'b0;
    chk("mkill mem_req_on", mem_req, 1);
    bus.kill_req_i = 1'b1;
    @(negedge clk);
    bus.kill_req_i = 1'b0;
    chk("mkill mem_req_off", mem_req, 0);
    chk("mkill busy", busy, 0);

    // Flush in MWAIT: drain the late response, no grant until the drain ends.
    @(negedge clk);
    bus.data_req_i = 1'b1; bus.address_index_i = 12'h020; bus.data_id_i = 3'd4;
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.tag_valid_i = 1'b1; bus.address_tag_i = 44'h77;
    @(negedge clk);
    bus.tag_valid_i = 1'b0;
    chk("flush mem_req", mem_req, 1);
    chk("flush mem_addr", mem_addr, 56'h77020);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; flush = 1'b1; bus.data_req_i = 1'b1;
    #1 chk("flush gnt_mwait", bus.data_gnt_o, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy_drain", busy, 1);
    #1 chk("flush gnt_drain", bus.data_gnt_o, 0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h1234; mem_err = 1'b0;
    #1 chk("flush gnt_drain2", bus.data_gnt_o, 0);
    @(negedge clk);
    mem_rvalid = 1'b0; bus.data_req_i = 1'b0;
    chk("flush rvalid", bus.data_rvalid_o, 0);
    chk("flush busy_end", busy, 0);
    @(negedge clk);
    chk("flush rvalid_late", bus.data_rvalid_o, 0);
    run_txn(vecs[0], 10);

    // Reset mid-transaction discards it and clears the response registers.
    @(negedge clk);
    bus.data_req_i = 1'b1; bus.address_index_i = 12'h008; bus.data_id_i = 3'd6;
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.tag_valid_i = 1'b1; bus.address_tag_i = 44'h9;
    @(negedge clk);
    bus.tag_valid_i = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst busy", busy, 0);
    chk("mrst rdata", bus.data_rdata_o, 0);
    chk("mrst rid", bus.data_rid_o, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("mrst rvalid", bus.data_rvalid_o, 0);
    @(negedge clk);
    chk("mrst rvalid_late", bus.data_rvalid_o, 0);
    chk("mrst busy_end", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
